conv_read_ctrl: RTL and testbench
=================================

CONV_READ_CTRL -- requirements
Module: conv_read_ctrl

Interface
REQ-001 Parameter DW, 8, element width of matrix/filter data.
REQ-002 Parameter ACCW, 20, accumulator/result width (9 x 255 x 255 = 585225 fits).
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run a full 3x3-over-4x4 convolution.
REQ-006 busy  output  1  high while a run is in progress.
REQ-007 done  output  1  one-cycle pulse after the last result.
REQ-008 en_INP, en_FIL  output  2 each  memory enables; 2'b00 idle, 2'b10 read; never 2'b11.
REQ-009 addr_A0, addr_A1, addr_A2  output  4 each  input-matrix read addresses.
REQ-010 addr_F0, addr_F1, addr_F2  output  4 each  filter read addresses.
REQ-011 out_A0..out_A2, out_F0..out_F2  input  DW each  memory read data, valid the cycle after the address.
REQ-012 res_data  output  ACCW  convolution result.
REQ-013 res_idx  output  2  output position p (row = p/2, col = p%2).
REQ-014 res_valid  output  1  one-cycle qualifier for res_data/res_idx.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DRAIN, DONE; IDLE->READ on start, READ->DRAIN after read 11, DRAIN->DONE after final result, DONE->IDLE unconditionally.
REQ-016 Call R the first cycle after start is sampled in IDLE; read i (0..11) SHALL be issued in cycle R+i with en_INP = en_FIL = 2'b10.
REQ-017 Read i SHALL target p = i/3, k = i%3: addr_Aj = (p/2 + k)*4 + p%2 + j, addr_Fj = 3k + j, j = 0..2.
REQ-018 Data of read i SHALL be multiplied pairwise (DW x DW unsigned), the three products summed, and the sum added into the accumulator in cycle R+i+1.
REQ-019 The accumulator SHALL clear at the first read of each position (k = 0), not carry across positions.
REQ-020 res_valid for position p SHALL be high in cycle R+3p+4 with res_idx = p; positions emitted in order 0,1,2,3.
REQ-021 done SHALL pulse in cycle R+14; busy SHALL be high R..R+13 and low from R+14.
REQ-022 Outside READ, en_INP/en_FIL SHALL be 2'b00 and all addresses 0.
REQ-023 start while not in IDLE (including DONE) SHALL be ignored with no effect on the run.
REQ-024 res_data SHALL hold its last value between res_valid pulses; no backpressure exists.
REQ-025 Arithmetic SHALL be unsigned, no saturation; ACCW covers worst case without overflow.

Reset
REQ-026 rst low SHALL asynchronously force IDLE, accumulator 0, all outputs 0 (busy, done, res_valid, res_data, res_idx, enables, addresses).
REQ-027 Reset mid-run SHALL abort; no res_valid or done pulse follows, and the next start runs a full fresh sequence.

Structure
REQ-028 Enable codes (IDLE 2'b00, READ 2'b10, WRITE 2'b11), matrix dimension 4, filter dimension 3 and the FSM state encoding SHALL live in a shared memory package used with memory_module.
REQ-029 Datapath SHALL be one sub-module, conv_mac3: three multipliers, adder tree, clearable accumulator.

Verification
REQ-030 A[i] = i (i = 0..15), F[i] = i+1 (i = 0..8), start -> results 303, 348, 483, 528 for p = 0..3 at R+4, R+7, R+10, R+13; done at R+14.
REQ-031 Address trace: cycle R addr_A = 0,1,2 / addr_F = 0,1,2; cycle R+5 addr_A = 9,10,11 / addr_F = 6,7,8; cycle R+11 addr_A = 13,14,15.
REQ-032 All A and F = 255 -> four results of 585225, no wrap.
REQ-033 start pulsed at R+3 and in the DONE cycle -> sequence unchanged, exactly four res_valid, one done, then IDLE.
REQ-034 rst low at R+6 -> all outputs 0 immediately; new start -> correct 303/348/483/528.
REQ-035 Idle check: for 20 cycles without start, enables stay 2'b00, addresses 0, busy/done/res_valid 0.

Source files
------------

// File: rtl/conv_read_ctrl_pkg.sv
// Shared memory/convolution package: enable codes, matrix and filter
// dimensions, FSM state encoding, read tag type and address helpers.
package conv_read_ctrl_pkg;

    // Memory enable codes shared with memory_module
    localparam logic [1:0] EN_IDLE  = 2'b00;
    localparam logic [1:0] EN_READ  = 2'b10;
    localparam logic [1:0] EN_WRITE = 2'b11;

    // Geometry: 3x3 filter sliding over a 4x4 input gives a 2x2 output
    localparam int MAT_DIM = 4;
    localparam int FIL_DIM = 3;
    localparam int OUT_DIM = MAT_DIM - FIL_DIM + 1;
    localparam int NUM_POS = OUT_DIM * OUT_DIM;

    // Last filter row index and last output position, sized for counters
    localparam logic [1:0] K_LAST = 2'(FIL_DIM - 1);
    localparam logic [1:0] P_LAST = 2'(NUM_POS - 1);

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bookkeeping that travels one cycle behind a read, alongside its data
    typedef struct packed {
        logic       vld;    // a read was issued last cycle
        logic       first;  // it was the first row (k = 0) of a position
        logic       last;   // it was the last row (k = 2) of a position
        logic [1:0] pos;    // output position it belongs to
    } rd_tag_t;

    // Input-matrix address of column j, filter row k, for output position pos
    function automatic logic [3:0] inp_addr(input logic [1:0] pos,
                                            input logic [1:0] k,
                                            input logic [1:0] j);
        logic [3:0] row;
        row = {3'b000, pos[1]} + {2'b00, k};
        return (row << 2) + {3'b000, pos[0]} + {2'b00, j};
    endfunction

    // Filter address of column j, filter row k
    function automatic logic [3:0] fil_addr(input logic [1:0] k,
                                            input logic [1:0] j);
        return ({2'b00, k} << 1) + {2'b00, k} + {2'b00, j};
    endfunction

endpackage

// File: rtl/conv_read_ctrl_mac3.sv
// conv_mac3: three unsigned multipliers, an adder tree and a clearable
// accumulator. acc_next is the value the accumulator takes this cycle.
module conv_mac3 #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc_en,
    input  logic            acc_clr,
    input  logic [DW-1:0]   a0,
    input  logic [DW-1:0]   a1,
    input  logic [DW-1:0]   a2,
    input  logic [DW-1:0]   f0,
    input  logic [DW-1:0]   f1,
    input  logic [DW-1:0]   f2,
    output logic [ACCW-1:0] acc_next
);

    localparam int PW = 2 * DW;

    logic [DW-1:0]   a_vec [3];
    logic [DW-1:0]   f_vec [3];
    logic [PW-1:0]   prod  [3];
    logic [ACCW-1:0] sum3;
    logic [ACCW-1:0] acc_reg;

    assign a_vec[0] = a0;
    assign a_vec[1] = a1;
    assign a_vec[2] = a2;
    assign f_vec[0] = f0;
    assign f_vec[1] = f1;
    assign f_vec[2] = f2;

    // Full-width products so 255 x 255 never truncates
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mul
            assign prod[gi] = {{DW{1'b0}}, a_vec[gi]} * {{DW{1'b0}}, f_vec[gi]};
        end
    endgenerate

    assign sum3     = ACCW'(prod[0]) + ACCW'(prod[1]) + ACCW'(prod[2]);
    // Clearing restarts the sum with this row so positions never mix
    assign acc_next = (acc_clr ? '0 : acc_reg) + sum3;

    // Accumulator register, only advances when a row's data is present
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (acc_en) begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/conv_read_ctrl.sv
// conv_read_ctrl: sequences twelve 3-wide reads of input matrix and filter,
// feeds them to conv_mac3 and emits the four 2x2 convolution results.
module conv_read_ctrl
    import conv_read_ctrl_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [1:0]      en_INP,
    output logic [1:0]      en_FIL,
    output logic [3:0]      addr_A0,
    output logic [3:0]      addr_A1,
    output logic [3:0]      addr_A2,
    output logic [3:0]      addr_F0,
    output logic [3:0]      addr_F1,
    output logic [3:0]      addr_F2,
    input  logic [DW-1:0]   out_A0,
    input  logic [DW-1:0]   out_A1,
    input  logic [DW-1:0]   out_A2,
    input  logic [DW-1:0]   out_F0,
    input  logic [DW-1:0]   out_F1,
    input  logic [DW-1:0]   out_F2,
    output logic [ACCW-1:0] res_data,
    output logic [1:0]      res_idx,
    output logic            res_valid
);

    logic [1:0]      state_reg, state_next;
    logic [1:0]      pos_reg;
    logic [1:0]      row_reg;
    logic            in_read;
    logic            last_read;
    rd_tag_t         tag_reg;
    logic [ACCW-1:0] acc_next;
    logic [ACCW-1:0] res_data_reg;
    logic [1:0]      res_idx_reg;
    logic            res_valid_reg;
    logic [3:0]      addr_a [3];
    logic [3:0]      addr_f [3];

    assign in_read   = (state_reg == ST_READ);
    assign last_read = in_read && (pos_reg == P_LAST) && (row_reg == K_LAST);

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_READ;
            ST_READ:  if (last_read) state_next = ST_DRAIN;
            ST_DRAIN: if (res_valid_reg && (res_idx_reg == P_LAST)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Position/filter-row counters walk the twelve reads, reset outside READ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_reg <= '0;
            row_reg <= '0;
        end else if (in_read) begin
            if (row_reg == K_LAST) begin
                row_reg <= '0;
                pos_reg <= pos_reg + 2'd1;
            end else begin
                row_reg <= row_reg + 2'd1;
            end
        end else begin
            pos_reg <= '0;
            row_reg <= '0;
        end
    end

    // Delay read bookkeeping by one cycle to line up with the memory data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_reg <= '0;
        end else begin
            tag_reg.vld   <= in_read;
            tag_reg.first <= in_read && (row_reg == 2'd0);
            tag_reg.last  <= in_read && (row_reg == K_LAST);
            tag_reg.pos   <= pos_reg;
        end
    end

    conv_mac3 #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (tag_reg.vld),
        .acc_clr  (tag_reg.first),
        .a0       (out_A0),
        .a1       (out_A1),
        .a2       (out_A2),
        .f0       (out_F0),
        .f1       (out_F1),
        .f2       (out_F2),
        .acc_next (acc_next)
    );

    // Capture the completed sum of a position; res_data holds until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_idx_reg   <= '0;
        end else begin
            res_valid_reg <= tag_reg.vld && tag_reg.last;
            if (tag_reg.vld && tag_reg.last) begin
                res_data_reg <= acc_next;
                res_idx_reg  <= tag_reg.pos;
            end
        end
    end

    // Read addresses per column j; forced to zero whenever not reading
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_addr
            assign addr_a[gi] = in_read ? inp_addr(pos_reg, row_reg, 2'(gi)) : 4'd0;
            assign addr_f[gi] = in_read ? fil_addr(row_reg, 2'(gi)) : 4'd0;
        end
    endgenerate

    assign addr_A0   = addr_a[0];
    assign addr_A1   = addr_a[1];
    assign addr_A2   = addr_a[2];
    assign addr_F0   = addr_f[0];
    assign addr_F1   = addr_f[1];
    assign addr_F2   = addr_f[2];
    assign en_INP    = in_read ? EN_READ : EN_IDLE;
    assign en_FIL    = in_read ? EN_READ : EN_IDLE;
    assign busy      = in_read || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);
    assign res_data  = res_data_reg;
    assign res_idx   = res_idx_reg;
    assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_conv_read_ctrl.sv
// Bench for conv_read_ctrl: registered-read memory model, directed runs,
// and a queue-based monitor checking every result and done pulse.
module tb_conv_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, res_valid;
    logic [1:0]  en_INP, en_FIL, res_idx;
    logic [3:0]  addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2;
    logic [7:0]  out_A0 = '0, out_A1 = '0, out_A2 = '0;
    logic [7:0]  out_F0 = '0, out_F1 = '0, out_F2 = '0;
    logic [19:0] res_data;

    logic [7:0]  mem_a [16];
    logic [7:0]  mem_f [9];

    typedef struct {
        logic [1:0]  idx;
        logic [19:0] data;
        int          cyc;
    } exp_t;

    exp_t res_q [$];
    int   done_q [$];
    exp_t mon_e;
    int   mon_d;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int r;

    conv_read_ctrl #(.DW(8), .ACCW(20)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .en_INP(en_INP), .en_FIL(en_FIL),
        .addr_A0(addr_A0), .addr_A1(addr_A1), .addr_A2(addr_A2),
        .addr_F0(addr_F0), .addr_F1(addr_F1), .addr_F2(addr_F2),
        .out_A0(out_A0), .out_A1(out_A1), .out_A2(out_A2),
        .out_F0(out_F0), .out_F1(out_F1), .out_F2(out_F2),
        .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data appears the cycle after the address when enabled
    always @(posedge clk) begin
        if (en_INP == 2'b10) begin
            out_A0 <= mem_a[addr_A0];
            out_A1 <= mem_a[addr_A1];
            out_A2 <= mem_a[addr_A2];
        end
        if (en_FIL == 2'b10) begin
            out_F0 <= mem_f[addr_F0];
            out_F1 <= mem_f[addr_F1];
            out_F2 <= mem_f[addr_F2];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s @cyc %0d: 0x%0h", name, cyc, act);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a result or done
    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (res_q.size() == 0) begin
                check("unexpected_res_valid", 32'(res_idx), 32'hFFFF_FFFF);
            end else begin
                mon_e = res_q.pop_front();
                check("res_data", 32'(res_data), 32'(mon_e.data));
                check("res_idx", 32'(res_idx), 32'(mon_e.idx));
                check("res_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (rst && done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                mon_d = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_d));
            end
        end
    end

    // Advance to the falling edge inside cycle t
    task automatic goto_cyc(input int t);
        int n;
        n = 0;
        @(negedge clk);
        while (cyc < t && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Pulse start for one cycle and queue the expected run
    task automatic run_start(input logic [19:0] e0, input logic [19:0] e1,
                             input logic [19:0] e2, input logic [19:0] e3,
                             output int rr);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        rr = cyc + 1;
        e.idx = 2'd0; e.data = e0; e.cyc = rr + 4;  res_q.push_back(e);
        e.idx = 2'd1; e.data = e1; e.cyc = rr + 7;  res_q.push_back(e);
        e.idx = 2'd2; e.data = e2; e.cyc = rr + 10; res_q.push_back(e);
        e.idx = 2'd3; e.data = e3; e.cyc = rr + 13; res_q.push_back(e);
        done_q.push_back(rr + 14);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic drain();
        int n;
        n = 0;
        while ((res_q.size() != 0 || done_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(res_q.size() + done_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] quiet_vec();
        return {1'b0, en_INP, en_FIL, addr_A0, addr_A1, addr_A2,
                addr_F0, addr_F1, addr_F2, busy, done, res_valid};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 9; i++)  mem_f[i] = 8'(i + 1);

        // Reset state
        #2;
        check("reset_ctrl", quiet_vec(), 32'd0);
        check("reset_res", {10'd0, res_data, res_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle for 20 cycles without start
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", quiet_vec(), 32'd0);
        end

        // Run 1: ramp data, with address trace and timing checks
        run_start(20'd303, 20'd348, 20'd483, 20'd528, r);
        goto_cyc(r);
        check("en_R", {28'd0, en_INP, en_FIL}, 32'b1010);
        check("addr_R", {8'd0, addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2},
              {8'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2});
        check("busy_R", 32'(busy), 32'd1);
        goto_cyc(r + 5);
        check("addr_R5", {8'd0, addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2},
              {8'd0, 4'd9, 4'd10, 4'd11, 4'd6, 4'd7, 4'd8});
        check("res_hold_R5", 32'(res_data), 32'd303);
        goto_cyc(r + 11);
        check("addr_A_R11", {20'd0, addr_A0, addr_A1, addr_A2}, {20'd0, 4'd13, 4'd14, 4'd15});
        goto_cyc(r + 12);
        check("en_R12", {28'd0, en_INP, en_FIL}, 32'd0);
        goto_cyc(r + 13);
        check("busy_R13", 32'(busy), 32'd1);
        goto_cyc(r + 14);
        check("busy_R14", 32'(busy), 32'd0);
        drain();

        // Run 2: all 255 -> worst-case sums, no wrap
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd255;
        for (int i = 0; i < 9; i++)  mem_f[i] = 8'd255;
        run_start(20'd585225, 20'd585225, 20'd585225, 20'd585225, r);
        drain();

        // Run 3: extra start pulses at R+3 and in DONE are ignored
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 9; i++)  mem_f[i] = 8'(i + 1);
        run_start(20'd303, 20'd348, 20'd483, 20'd528, r);
        goto_cyc(r + 3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto_cyc(r + 14);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto_cyc(r + 15);
        check("idle_after_done", quiet_vec(), 32'd0);
        goto_cyc(r + 17);
        check("idle_after_done2", quiet_vec(), 32'd0);
        drain();

        // Run 4: reset at R+6 aborts, then a fresh run completes
        run_start(20'd303, 20'd348, 20'd483, 20'd528, r);
        goto_cyc(r + 6);
        rst = 1'b0;
        #1;
        res_q.delete();
        done_q.delete();
        check("abort_ctrl", quiet_vec(), 32'd0);
        check("abort_res", {10'd0, res_data, res_idx}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_pulse", quiet_vec(), 32'd0);
        run_start(20'd303, 20'd348, 20'd483, 20'd528, r);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
